// File: rtl/dp_fifo_ctrl.sv
// Dual-port FIFO controller: pointer/occupancy bookkeeping and strobes for an
// external dual-port RAM with a registered, one-cycle-latency read port.
module dp_fifo_ctrl #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AF_LEVEL = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clr_err,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              mem_enb,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic [DATA_W-1:0] mem_w_data,
  input  logic [DATA_W-1:0] mem_r_data
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [CNT_W-1:0]  count_nxt;
  logic              push_acc;
  logic              pop_acc;
  logic              ovf_set;
  logic              unf_set;

  // Acceptance uses the registered flags; gated by reset so strobes are quiet in reset.
  always_comb begin
    push_acc = rst & push & ~full;
    pop_acc  = rst & pop & ~empty;
    ovf_set  = push & full;
    unf_set  = pop & empty;
  end

  // Memory strobes and addresses follow the accepted requests in the same cycle.
  always_comb begin
    mem_wr     = push_acc;
    mem_rd     = pop_acc;
    mem_enb    = push_acc | pop_acc;
    mem_w_addr = wptr;
    mem_r_addr = rptr;
    mem_w_data = push_data;
    pop_data   = mem_r_data;
  end

  // Next occupancy: simultaneous accepted push and pop cancel out.
  always_comb begin
    count_nxt = count;
    unique case ({push_acc, pop_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and flags; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push_acc) wptr <= wptr + ADDR_W'(1);
      if (pop_acc)  rptr <= rptr + ADDR_W'(1);
      count       <= count_nxt;
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == CNT_W'(DEPTH));
      almost_full <= (count_nxt >= CNT_W'(AF_LEVEL));
    end
  end

  // Read data arrives one cycle after an accepted pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pop_acc;
    end
  end

  // Sticky error flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dp_fifo_ctrl.sv
// Bench for dp_fifo_ctrl: external RAM model plus a queue-based reference FIFO.
module tb_dp_fifo_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AF     = 14;

  logic              clk;
  logic              rst;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              clr_err;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              mem_enb;
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_w_addr;
  logic [ADDR_W-1:0] mem_r_addr;
  logic [DATA_W-1:0] mem_w_data;
  logic [DATA_W-1:0] mem_r_data;

  dp_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .clr_err(clr_err), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow), .mem_enb(mem_enb), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External dual-port RAM with registered read port
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_w_addr] <= mem_w_data;
    if (mem_rd) mem_r_data <= ram[mem_r_addr];
  end

  // Reference model state
  logic [DATA_W-1:0] fq[$];
  int unsigned       wcnt, rcnt;
  bit                ovf, unf;
  bit                exp_pv;
  logic [DATA_W-1:0] exp_pd;

  int unsigned total;
  int unsigned passed;
  int unsigned failed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    wcnt   = 0;
    rcnt   = 0;
    ovf    = 1'b0;
    unf    = 1'b0;
    exp_pv = 1'b0;
  endtask

  task automatic chk_state();
    chk("count", 32'(count), fq.size());
    chk("empty", 32'(empty), 32'(fq.size() == 0));
    chk("full", 32'(full), 32'(fq.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(fq.size() >= AF));
    chk("overflow", 32'(overflow), 32'(ovf));
    chk("underflow", 32'(underflow), 32'(unf));
  endtask

  // One clock cycle of stimulus with strobe checks before and state checks after the edge
  task automatic step(input bit p, input logic [DATA_W-1:0] d, input bit q, input bit c);
    bit full_e, empty_e, pa, qa;
    @(negedge clk);
    push = p; push_data = d; pop = q; clr_err = c;
    #1;
    full_e  = (fq.size() == DEPTH);
    empty_e = (fq.size() == 0);
    pa = p && !full_e;
    qa = q && !empty_e;
    chk("pop_valid", 32'(pop_valid), 32'(exp_pv));
    if (exp_pv) chk("pop_data", 32'(pop_data), 32'(exp_pd));
    chk("mem_wr", 32'(mem_wr), 32'(pa));
    chk("mem_rd", 32'(mem_rd), 32'(qa));
    chk("mem_enb", 32'(mem_enb), 32'(pa | qa));
    if (pa) begin
      chk("mem_w_addr", 32'(mem_w_addr), wcnt % DEPTH);
      chk("mem_w_data", 32'(mem_w_data), 32'(d));
    end
    if (qa) chk("mem_r_addr", 32'(mem_r_addr), rcnt % DEPTH);
    if (p && full_e) ovf = 1'b1;
    else if (c)      ovf = 1'b0;
    if (q && empty_e) unf = 1'b1;
    else if (c)       unf = 1'b0;
    exp_pv = qa;
    if (qa) begin
      exp_pd = fq.pop_front();
      rcnt++;
    end
    if (pa) begin
      fq.push_back(d);
      wcnt++;
    end
    @(posedge clk);
    #1;
    chk_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk_state();
    chk("rst_pop_valid", 32'(pop_valid), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    push = 1'b0; push_data = '0; pop = 1'b0; clr_err = 1'b0;
    rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    #3;
    chk_state();
    chk("rst_pop_valid", 32'(pop_valid), 32'(0));
    chk("rst_mem_enb", 32'(mem_enb), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Pop on an empty FIFO: rejected, underflow sticks, then cleared
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("underflow_held", 32'(underflow), 32'(1));
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Ordered push/pop of three words
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("empty_after_three", 32'(empty), 32'(1));

    // Fill to full, reject one more push, clear the sticky overflow, drain
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("count_full", 32'(count), 32'(16));
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("overflow_set", 32'(overflow), 32'(1));
    step(1'b1, 8'hEF, 1'b1, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("count_held_5", 32'(count), 32'(5));
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);

    // Wrap-around: 20 push/pop pairs starting from zeroed pointers
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic: fill-biased, then drain-biased
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 99) < 75, 8'($urandom), $urandom_range(0, 99) < 35,
           $urandom_range(0, 99) < 8);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 99) < 35, 8'($urandom), $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 8);

    // Reset asserted mid-burst with count 7 and a read pending
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("count_before_rst", 32'(count), 32'(7));
    chk("pending_valid", 32'(pop_valid), 32'(1));
    push = 1'b1; pop = 1'b1;
    #1 rst = 1'b0;
    #1;
    model_reset();
    chk("async_count", 32'(count), 32'(0));
    chk("async_empty", 32'(empty), 32'(1));
    chk("async_pop_valid", 32'(pop_valid), 32'(0));
    chk("async_mem_wr", 32'(mem_wr), 32'(0));
    chk("async_mem_rd", 32'(mem_rd), 32'(0));
    chk("async_mem_enb", 32'(mem_enb), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    push = 1'b0; pop = 1'b0;

    // Normal operation resumes after reset release
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dp_fifo_ctrl.md
DP_FIFO_CTRL -- requirements
Module: dp_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, memory address width; DEPTH = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 8, data word width.
REQ-003 SHALL have parameter AF_LEVEL, default 14, almost_full threshold in entries.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named clk and rst as elsewhere in the codebase.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port push  input  1  write request.
REQ-008 SHALL have port push_data  input  DATA_W  write data.
REQ-009 SHALL have port pop  input  1  read request.
REQ-010 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-011 SHALL have port pop_data  output  DATA_W  read data.
REQ-012 SHALL have port pop_valid  output  1  pop_data valid this cycle.
REQ-013 SHALL have port full / empty / almost_full  output  1 each  occupancy flags.
REQ-014 SHALL have port count  output  ADDR_W+1  current occupancy.
REQ-015 SHALL have port overflow / underflow  output  1 each  sticky error flags.
REQ-016 SHALL have port mem_enb, mem_wr, mem_rd  output  1 each  dual-port memory strobes.
REQ-017 SHALL have port mem_w_addr / mem_r_addr  output  ADDR_W each  memory write/read address.
REQ-018 SHALL have port mem_w_data  output  DATA_W  memory write data.
REQ-019 SHALL have port mem_r_data  input  DATA_W  memory read data, registered, 1-cycle latency after mem_rd.

Function
REQ-020 SHALL define push_acc = push & ~full and pop_acc = pop & ~empty, both evaluated on current-cycle registered flags.
REQ-021 SHALL drive mem_wr = push_acc, mem_rd = pop_acc, mem_enb = push_acc | pop_acc, combinationally in the same cycle.
REQ-022 SHALL drive mem_w_addr = wptr, mem_r_addr = rptr and mem_w_data = push_data.
REQ-023 SHALL increment wptr modulo DEPTH on push_acc and rptr modulo DEPTH on pop_acc; wrap from DEPTH-1 to 0 without a gap.
REQ-024 SHALL update count as +1 on push_acc only, -1 on pop_acc only, and unchanged when both are asserted.
REQ-025 SHALL register empty = (next count == 0), full = (next count == DEPTH) and almost_full = (next count >= AF_LEVEL).
REQ-026 SHALL, on simultaneous push and pop: when empty, accept the push only; when full, accept the pop only; otherwise accept both.
REQ-027 SHALL assert pop_valid exactly one cycle after each pop_acc, with pop_data = mem_r_data in that cycle; the pop-to-data latency is fixed at 1.
REQ-028 SHALL set overflow on push & full and underflow on pop & empty; both flags hold until clr_err or reset.
REQ-029 SHALL give a set event priority over clr_err when both occur in the same cycle.
REQ-030 SHALL, on a rejected request, leave pointers, count and memory strobes unaffected.
REQ-031 SHALL preserve FIFO order; data is popped in push order.

Reset
REQ-032 SHALL, while rst = 0, asynchronously force wptr = 0, rptr = 0, count = 0, empty = 1, full = 0, almost_full = 0, pop_valid = 0, overflow = 0 and underflow = 0.
REQ-033 SHALL force mem_wr, mem_rd and mem_enb to 0 while rst = 0.
REQ-034 SHALL drop a pop_valid that is pending when reset asserts mid-operation; memory contents are not cleared.
REQ-035 SHALL resume normal operation on the first rising clk after rst deasserts.

Verification
REQ-036 Bench SHALL cover: after reset, pop with no prior push -> no mem_rd, pop_valid stays 0, underflow = 1, count = 0.
REQ-037 Bench SHALL cover: push 0x11, 0x22, 0x33, then three pops -> pop_valid on 3 cycles with pop_data 0x11, 0x22, 0x33 in order; empty = 1 at end.
REQ-038 Bench SHALL cover: 16 pushes (ADDR_W = 4) -> full = 1, count = 16; the 17th push gives mem_wr = 0 and overflow = 1; clr_err clears overflow.
REQ-039 Bench SHALL cover: with count = 5, push and pop in the same cycle -> count stays 5, mem_wr = mem_rd = 1.
REQ-040 Bench SHALL cover: wrap-around, 20 push/pop pairs -> mem_w_addr cycles 0..15,0..3, and data still matches.
REQ-041 Bench SHALL cover: rst pulsed low mid-burst with count = 7 -> count = 0, empty = 1, pop_valid = 0 immediately, without waiting for a clk edge.
